codificador_sensores_piso: RTL

Encoder side of the floor-code interface for the montacargas. It samples the three floor limit switches, debounces them and tracks position with a small FSM. It then drives the 3-bit floor code consumed by the 7-segment display decoder: 000 = off/unknown, 001–011 = floors 1–3, 111 = alarm "A". It sits between the cabin sensor inputs and both the display path and the main control FSM.

---
 rtl/montacargas_pkg.sv | 35 +++
 rtl/codificador_sensores_piso_antirrebote.sv | 50 +++++
 rtl/codificador_sensores_piso.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/montacargas_pkg.sv
// Shared floor-code constants and cabin-position FSM states for the montacargas
// encoder and the 7-segment display decoder.
package montacargas_pkg;

    localparam logic [2:0] PISO_APAGADO  = 3'b000;
    localparam logic [2:0] PISO_1        = 3'b001;
    localparam logic [2:0] PISO_2        = 3'b010;
    localparam logic [2:0] PISO_3        = 3'b011;
    localparam logic [2:0] CODIGO_ALARMA = 3'b111;

    typedef enum logic [1:0] {
        INICIO      = 2'd0,
        EN_PISO     = 2'd1,
        ENTRE_PISOS = 2'd2,
        FALLA       = 2'd3
    } estado_piso_t;

    function automatic logic [1:0] cuenta_activos(input logic [2:0] s);
        return {1'b0, s[0]} + {1'b0, s[1]} + {1'b0, s[2]};
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [2:0] codigo_de_piso(input logic [2:0] s);
        logic [2:0] codigo;
        codigo = PISO_APAGADO;
        if (s[2])
            codigo = PISO_3;
        else if (s[1])
            codigo = PISO_2;
        else if (s[0])
            codigo = PISO_1;
        return codigo;
    endfunction

endpackage

// File: rtl/codificador_sensores_piso_antirrebote.sv
// Single-bit limit-switch conditioner: 2-FF synchronizer followed by a
// debouncer that accepts a change after DEBOUNCE_CYCLES consecutive samples.
module antirrebote #(
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic entrada,
    output logic salida
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CUENTA_FINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          estable_q, estable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d   = entrada;
        sync2_d   = sync1_q;
        estable_d = estable_q;
        cnt_d     = '0;
        if (sync2_q != estable_q) begin
            // The accepting sample is the DEBOUNCE_CYCLES-th differing one.
            if (cnt_q == CUENTA_FINAL)
                estable_d = sync2_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            estable_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            estable_q <= estable_d;
            cnt_q     <= cnt_d;
        end
    end

    assign salida = estable_q;

endmodule

// File: rtl/codificador_sensores_piso.sv
// Floor-code encoder: debounces the three limit switches and tracks cabin position.
// Define PISO_TIMEOUT_EN to build the between-floors watchdog.
//
// state       | meaning
// INICIO      | no floor seen since reset, code 000
// EN_PISO     | stopped exactly at a floor, pisoValido=1
// ENTRE_PISOS | between floors, code holds last floor
// FALLA       | sensor conflict or watchdog expiry, code 111, sticky until reset
module codificador_sensores_piso
    import montacargas_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int TIMEOUT_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sensorPiso,
    input  logic       enMovimiento,
    output logic [2:0] pisoEnBinario,
    output logic       pisoValido,
    output logic       alarma
);

    logic [2:0] piso_deb;

    for (genvar i = 0; i < 3; i++) begin : g_bit
        antirrebote #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_antirrebote (
            .clk    (clk),
            .reset  (reset),
            .entrada(sensorPiso[i]),
            .salida (piso_deb[i])
        );
    end

    logic [1:0] n_activos;
    logic       uno, multi;
    logic [2:0] codigo_uno;

    assign n_activos  = cuenta_activos(piso_deb);
    assign uno        = (n_activos == 2'd1);
    assign multi      = (n_activos > 2'd1);
    assign codigo_uno = codigo_de_piso(piso_deb);

    estado_piso_t estado_q, estado_d;
    logic [2:0]   piso_q, piso_d;
    logic [2:0]   codigo_q, codigo_d;
    logic         valido_q, valido_d;
    logic         alarma_q, alarma_d;
    logic         vencido;

`ifdef PISO_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] LIMITE = WW'(TIMEOUT_CYCLES);

    logic [WW-1:0] wd_q, wd_d;

    assign vencido = (wd_q == LIMITE);

    // Counts moving time only; an emergency stop between floors holds the count.
    always_comb begin
        wd_d = '0;
        if (estado_q == ENTRE_PISOS && estado_d == ENTRE_PISOS)
            wd_d = enMovimiento ? wd_q + 1'b1 : wd_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`else
    logic unused_cfg;

    assign vencido    = 1'b0;
    assign unused_cfg = enMovimiento ^ (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        estado_d = estado_q;
        piso_d   = piso_q;
        case (estado_q)
            INICIO: begin
                if (multi) begin
                    estado_d = FALLA;
                end else if (uno) begin
                    estado_d = EN_PISO;
                    piso_d   = codigo_uno;
                end
            end
            EN_PISO: begin
                if (multi)
                    estado_d = FALLA;
                else if (uno)
                    piso_d = codigo_uno;
                else
                    estado_d = ENTRE_PISOS;
            end
            ENTRE_PISOS: begin
                if (multi || vencido) begin
                    estado_d = FALLA;
                end else if (uno) begin
                    estado_d = EN_PISO;
                    piso_d   = codigo_uno;
                end
            end
            FALLA: estado_d = FALLA;
        endcase

        case (estado_d)
            INICIO:  codigo_d = PISO_APAGADO;
            FALLA:   codigo_d = CODIGO_ALARMA;
            default: codigo_d = piso_d;
        endcase
        valido_d = (estado_d == EN_PISO);
        alarma_d = (estado_d == FALLA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= INICIO;
            piso_q   <= PISO_APAGADO;
            codigo_q <= PISO_APAGADO;
            valido_q <= 1'b0;
            alarma_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            piso_q   <= piso_d;
            codigo_q <= codigo_d;
            valido_q <= valido_d;
            alarma_q <= alarma_d;
        end
    end

    assign pisoEnBinario = codigo_q;
    assign pisoValido    = valido_q;
    assign alarma        = alarma_q;

endmodule
